// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column scan, full-snapshot debounce, single-key decode.
// Optional auto-repeat while a single key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_CNT       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int unsigned       SLOT_W    = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CNT - 1);
    localparam logic [3:0]        DEB_MAX   = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HELD  = 2'd1;
    localparam logic [1:0] S_GHOST = 2'd2;

    if (SCAN_CNT < 4 || DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_param_err
        $error("keypad_scan_ctrl: illegal parameter set");
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = ($clog2(REPEAT_DELAY + 1) < 6) ? 6 : $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD  = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             raw_single_q;
`endif

    logic [3:0]        row_s1;
    logic [3:0]        row_s2;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [15:0]       snap_cur;
    logic [15:0]       prev_snap;
    logic [15:0]       acc_snap;
    logic [3:0]        stable_cnt;
    logic              accept_q;
    logic              sweep_q;

    logic              slot_end_c;
    logic              sweep_end_c;
    logic [15:0]       snap_full_c;
    logic [3:0]        stable_nxt_c;
    logic              single_c;
    logic [3:0]        idx_c;
    logic              raw_single_c;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              key_valid_nxt;
    logic [3:0]        key_code_nxt;
    logic              key_down_nxt;

    // Merge the current column's rows into the snapshot and evaluate debounce.
    always_comb begin
        slot_end_c  = (slot_cnt == SLOT_LAST);
        sweep_end_c = slot_end_c && (col_idx == 2'd3);
        snap_full_c = snap_cur;
        for (int r = 0; r < 4; r++) begin
            snap_full_c[{2'(r), col_idx}] = ~row_s2[r];
        end
        if (snap_full_c == prev_snap) begin
            stable_nxt_c = (stable_cnt >= DEB_MAX) ? DEB_MAX : stable_cnt + 4'd1;
        end else begin
            stable_nxt_c = 4'd1;
        end
        raw_single_c = (snap_full_c != 16'd0) &&
                       ((snap_full_c & (snap_full_c - 16'd1)) == 16'd0);
    end

    // Row synchronizer, column rotation and sweep bookkeeping.
    always_ff @(posedge clk) begin
        if (!clr) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            slot_cnt   <= '0;
            col_idx    <= 2'd0;
            col        <= 4'b1110;
            snap_cur   <= 16'd0;
            prev_snap  <= 16'd0;
            acc_snap   <= 16'd0;
            stable_cnt <= 4'd0;
            accept_q   <= 1'b0;
            sweep_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
            raw_single_q <= 1'b0;
`endif
        end else begin
            row_s1   <= row;
            row_s2   <= row_s1;
            accept_q <= 1'b0;
            sweep_q  <= 1'b0;
            if (slot_end_c) begin
                slot_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                col      <= {col[2:0], col[3]};
                snap_cur <= snap_full_c;
                if (sweep_end_c) begin
                    prev_snap  <= snap_full_c;
                    stable_cnt <= stable_nxt_c;
                    sweep_q    <= 1'b1;
`ifdef KEY_REPEAT_EN
                    raw_single_q <= raw_single_c;
`endif
                    if (stable_nxt_c == DEB_MAX && stable_cnt != DEB_MAX) begin
                        accept_q <= 1'b1;
                        acc_snap <= snap_full_c;
                    end
                end
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Decode the accepted snapshot: single-key test and key index.
    always_comb begin
        single_c = (acc_snap != 16'd0) && ((acc_snap & (acc_snap - 16'd1)) == 16'd0);
        idx_c    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (acc_snap[i]) begin
                idx_c = 4'(i);
            end
        end
    end

    // Next-state and output logic; transitions only on accepted snapshots.
    always_comb begin
        state_nxt     = state;
        key_valid_nxt = 1'b0;
        key_code_nxt  = key_code;
        key_down_nxt  = key_down;
`ifdef KEY_REPEAT_EN
        rpt_cnt_nxt   = rpt_cnt;
`endif
        case (state)
            S_IDLE: begin
`ifdef KEY_REPEAT_EN
                rpt_cnt_nxt = '0;
`endif
                if (accept_q) begin
                    if (single_c) begin
                        state_nxt     = S_HELD;
                        key_valid_nxt = 1'b1;
                        key_code_nxt  = idx_c;
                        key_down_nxt  = 1'b1;
                    end else if (acc_snap != 16'd0) begin
                        state_nxt = S_GHOST;
                    end
                end
            end
            S_HELD: begin
                if (accept_q && acc_snap == 16'd0) begin
                    state_nxt    = S_IDLE;
                    key_down_nxt = 1'b0;
                end
`ifdef KEY_REPEAT_EN
                else if (sweep_q) begin
                    // Counter clears and pauses whenever the sweep is not a lone key.
                    if (!raw_single_q) begin
                        rpt_cnt_nxt = '0;
                    end else if (rpt_cnt + RPT_W'(1) == RPT_DELAY_V) begin
                        key_valid_nxt = 1'b1;
                        rpt_cnt_nxt   = RPT_RELOAD;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                    end
                end
`endif
            end
            S_GHOST: begin
                if (accept_q && acc_snap == 16'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            key_valid <= key_valid_nxt;
            key_code  <= key_code_nxt;
            key_down  <= key_down_nxt;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= rpt_cnt_nxt;
`endif
        end
    end

`ifndef KEY_REPEAT_EN
    logic unused_raw_single;
    assign unused_raw_single = raw_single_c;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a combinational 4x4 keypad model.
module tb_keypad_scan_ctrl;

    localparam int SWEEP = 40;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] keys = 16'd0;

    int          vec = 0;
    int          errs = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          adj_cnt = 0;
    int          pulse_cyc [64];
    logic [3:0]  pulse_code [64];
    logic        kv_prev = 1'b0;

    keypad_scan_ctrl #(
        .SCAN_CNT(10),
        .DEBOUNCE_SCANS(4),
        .REPEAT_DELAY(5),
        .REPEAT_RATE(2)
    ) dut (
        .clk(clk),
        .clr(clr),
        .row(row),
        .col(col),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_down(key_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Row r reads low when a closed key in row r sits on a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            if (pulse_cnt < 64) begin
                pulse_cyc[pulse_cnt]  = cyc;
                pulse_code[pulse_cnt] = key_code;
            end
            pulse_cnt = pulse_cnt + 1;
            if (kv_prev) adj_cnt = adj_cnt + 1;
        end
        kv_prev = key_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_sweep();
        logic [3:0] pc;
        pc = col;
        for (int i = 0; i < 2 * SWEEP; i++) begin
            @(negedge clk);
            if (col == 4'b1110 && pc != 4'b1110) return;
            pc = col;
        end
        vec++;
        errs++;
        $display("FAIL align: col=%b never re-entered 1110", col);
    endtask

    task automatic wait_pulse(input int base, input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (pulse_cnt > base) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col [4];
        exp_col[0] = 4'b1101;
        exp_col[1] = 4'b1011;
        exp_col[2] = 4'b0111;
        exp_col[3] = 4'b1110;
        clr  = 1'b0;
        keys = 16'd0;
        wait_cyc(5);
        clr = 1'b1;
        vec++;
        if ({col, key_valid, key_code, key_down} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_outputs: col=%b kv=%b code=%0d down=%b, want 1110/0/0/0",
                     col, key_valid, key_code, key_down);
        end
        for (int k = 0; k < 4; k++) begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            vec++;
            if (col !== exp_col[k]) begin
                errs++;
                $display("FAIL col_rotate[%0d]: col=%b want %b", k, col, exp_col[k]);
            end
            repeat (0) @(posedge clk);
            // Re-align to count posedges from the negedge just observed.
            wait_cyc(0);
            if (k < 3) begin
                // The negedge above consumed no extra posedge; next loop adds 10 more.
            end
        end
    endtask

    task automatic test_single_key();
        int base, t0, lat;
        bit got;
        base = pulse_cnt;
        align_sweep();
        keys[9] = 1'b1;
        t0 = cyc;
        wait_pulse(base, 6 * SWEEP, got);
        vec++;
        if (got !== 1'b1) begin
            errs++;
            $display("FAIL single_pulse: no key_valid within %0d cycles", 6 * SWEEP);
        end else begin
            lat = pulse_cyc[base] - t0;
            vec++;
            if (lat < 160 || lat > 203) begin
                errs++;
                $display("FAIL single_latency: got %0d cycles want 160..203", lat);
            end
            vec++;
            if (pulse_code[base] !== 4'd9) begin
                errs++;
                $display("FAIL single_code: got %0d want 9", pulse_code[base]);
            end
        end
        @(negedge clk);
        vec++;
        if (key_down !== 1'b1) begin
            errs++;
            $display("FAIL single_down: key_down=%b want 1", key_down);
        end
        wait_cyc(20 * SWEEP - (cyc - t0));
        vec++;
        if (pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL single_count: got %0d pulses want 1", pulse_cnt - base);
        end
        keys = 16'd0;
        wait_cyc(2 * SWEEP);
        vec++;
        if (key_down !== 1'b1) begin
            errs++;
            $display("FAIL release_early: key_down=%b want 1 before debounce", key_down);
        end
        wait_cyc(4 * SWEEP);
        vec++;
        if ({key_down, key_code} !== {1'b0, 4'd9} || pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL release: down=%b code=%0d pulses=%0d want 0/9/1",
                     key_down, key_code, pulse_cnt - base);
        end
    endtask

    task automatic test_bounce();
        int base;
        bit got;
        base = pulse_cnt;
        align_sweep();
        for (int i = 0; i < 6; i++) begin
            keys[3] = (i % 2 == 0);
            wait_cyc(15);
        end
        keys[3] = 1'b1;
        vec++;
        if (pulse_cnt !== base) begin
            errs++;
            $display("FAIL bounce_quiet: got %0d pulses during bounce want 0", pulse_cnt - base);
        end
        wait_pulse(base, 7 * SWEEP, got);
        vec++;
        if (got !== 1'b1 || pulse_code[base] !== 4'd3) begin
            errs++;
            $display("FAIL bounce_pulse: got=%b code=%0d want 1/3", got, pulse_code[base]);
        end
        wait_cyc(3 * SWEEP);
        vec++;
        if (pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL bounce_count: got %0d pulses want 1", pulse_cnt - base);
        end
        keys = 16'd0;
        wait_cyc(6 * SWEEP);
        vec++;
        if (key_down !== 1'b0) begin
            errs++;
            $display("FAIL bounce_release: key_down=%b want 0", key_down);
        end
    endtask

    task automatic test_multi();
        int base;
        bit got;
        base = pulse_cnt;
        align_sweep();
        keys[5] = 1'b1;
        wait_pulse(base, 6 * SWEEP, got);
        vec++;
        if (got !== 1'b1 || pulse_code[base] !== 4'd5) begin
            errs++;
            $display("FAIL multi_first: got=%b code=%0d want 1/5", got, pulse_code[base]);
        end
        keys[6] = 1'b1;
        wait_cyc(6 * SWEEP);
        vec++;
        if ({key_down, key_code} !== {1'b1, 4'd5} || pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL multi_add: down=%b code=%0d pulses=%0d want 1/5/1",
                     key_down, key_code, pulse_cnt - base);
        end
        keys = 16'd0;
        wait_cyc(6 * SWEEP);
        vec++;
        if (key_down !== 1'b0) begin
            errs++;
            $display("FAIL multi_release: key_down=%b want 0", key_down);
        end
        keys = 16'h9000;
        wait_cyc(8 * SWEEP);
        vec++;
        if ({key_down, key_code} !== {1'b0, 4'd5} || pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL ghost_hold: down=%b code=%0d pulses=%0d want 0/5/1",
                     key_down, key_code, pulse_cnt - base);
        end
        keys = 16'd0;
        wait_cyc(6 * SWEEP);
        vec++;
        if (pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL ghost_release: got %0d pulses want 1", pulse_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int base, tr, lat;
        bit got;
        base = pulse_cnt;
        align_sweep();
        keys[0] = 1'b1;
        wait_cyc(100);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        tr = cyc;
        vec++;
        if ({col, key_valid, key_code, key_down} !== {4'b1110, 1'b0, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL midreset_outputs: col=%b kv=%b code=%0d down=%b want 1110/0/0/0",
                     col, key_valid, key_code, key_down);
        end
        wait_pulse(base, 6 * SWEEP, got);
        vec++;
        if (got !== 1'b1) begin
            errs++;
            $display("FAIL midreset_pulse: no key_valid after re-debounce");
        end else begin
            lat = pulse_cyc[base] - tr;
            vec++;
            if (lat < 155 || lat > 205 || pulse_code[base] !== 4'd0) begin
                errs++;
                $display("FAIL midreset_timing: latency=%0d code=%0d want 155..205/0",
                         lat, pulse_code[base]);
            end
        end
        keys = 16'd0;
        wait_cyc(6 * SWEEP);
        vec++;
        if (key_down !== 1'b0 || pulse_cnt - base !== 1) begin
            errs++;
            $display("FAIL midreset_release: down=%b pulses=%0d want 0/1",
                     key_down, pulse_cnt - base);
        end
    endtask

    task automatic test_repeat();
        int base, p0, n_exp;
        int exp_off [5];
        bit got;
        exp_off[0] = 0;
        exp_off[1] = 5 * SWEEP;
        exp_off[2] = 7 * SWEEP;
        exp_off[3] = 9 * SWEEP;
        exp_off[4] = 11 * SWEEP;
`ifdef KEY_REPEAT_EN
        n_exp = 5;
`else
        n_exp = 1;
`endif
        base = pulse_cnt;
        align_sweep();
        keys[14] = 1'b1;
        wait_pulse(base, 6 * SWEEP, got);
        vec++;
        if (got !== 1'b1) begin
            errs++;
            $display("FAIL repeat_first: no key_valid for key 14");
        end else begin
            p0 = pulse_cyc[base];
            wait_cyc(460 - (cyc - p0));
            keys = 16'd0;
            wait_cyc(6 * SWEEP);
            vec++;
            if (pulse_cnt - base !== n_exp) begin
                errs++;
                $display("FAIL repeat_count: got %0d pulses want %0d", pulse_cnt - base, n_exp);
            end else begin
                for (int k = 0; k < n_exp; k++) begin
                    vec++;
                    if (pulse_cyc[base + k] - p0 !== exp_off[k] || pulse_code[base + k] !== 4'd14) begin
                        errs++;
                        $display("FAIL repeat_pulse[%0d]: offset=%0d code=%0d want %0d/14",
                                 k, pulse_cyc[base + k] - p0, pulse_code[base + k], exp_off[k]);
                    end
                end
            end
            vec++;
            if (key_down !== 1'b0) begin
                errs++;
                $display("FAIL repeat_release: key_down=%b want 0", key_down);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_reset_mid();
        test_repeat();
        vec++;
        if (adj_cnt !== 0) begin
            errs++;
            $display("FAIL pulse_spacing: %0d adjacent key_valid cycles want 0", adj_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
